// File: rtl/sequenciador_cozimento_pkg.sv
// Shared definitions for the microwave cooking sequencer: FSM encodings and BCD constants.
package sequenciador_cozimento_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COOK  = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } estado_t;

   localparam logic [3:0] ZERO = 4'd0;
   localparam logic [3:0] NINE = 4'd9;
   localparam logic [3:0] FIVE = 4'd5;

   localparam int NUM_DIG = 4;

   // Digit order inside the packed time word: [3]=min_tens .. [0]=sec_ones.
   typedef logic [NUM_DIG-1:0][3:0] tempo_t;

   function automatic logic is_bcd(input logic [3:0] d);
      return d <= NINE;
   endfunction

endpackage

// File: rtl/sequenciador_cozimento_if.sv
// Front-end / magnetron / display signal bundle for the cooking sequencer.
interface sequenciador_cozimento_if;
   logic       tick_1hz;
   logic       startn;
   logic       stopn;
   logic       clearn;
   logic       door_closed;
   logic       key_valid;
   logic [3:0] key_digit;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       mag_on;
   logic       timer_done;
   logic       beep;
   logic [1:0] state;

   modport master (
      output tick_1hz, startn, stopn, clearn, door_closed, key_valid, key_digit,
      input  min_tens, min_ones, sec_tens, sec_ones, mag_on, timer_done, beep, state
   );

   modport slave (
      input  tick_1hz, startn, stopn, clearn, door_closed, key_valid, key_digit,
      output min_tens, min_ones, sec_tens, sec_ones, mag_on, timer_done, beep, state
   );
endinterface

// File: rtl/sequenciador_cozimento_contador_bcd_regressivo.sv
// Four-digit MM:SS BCD down-counter with clear, keypad shift-in and decrement.
module contador_bcd_regressivo
   import sequenciador_cozimento_pkg::*;
(
   input  logic       clock,
   input  logic       resetn,
   input  logic       clr,
   input  logic       load,
   input  logic [3:0] digit_in,
   input  logic       dec,
   output tempo_t     digits,
   output logic       zero,
   output logic       last
);

   assign zero = (digits == '0);
   // Only 00:01 can step to 00:00, so the FSM can enter DONE on the same tick.
   assign last = (digits == tempo_t'(16'h0001));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         digits <= '0;
      end else if (clr) begin
         digits <= '0;
      end else if (load) begin
         digits <= {digits[2:0], digit_in};
      end else if (dec && !zero) begin
         if (digits[0] != ZERO)
            digits[0] <= digits[0] - 4'd1;
         else if (digits[1] != ZERO)
            digits[1:0] <= {digits[1] - 4'd1, NINE};
         else if (digits[2] != ZERO)
            digits[2:0] <= {digits[2] - 4'd1, FIVE, NINE};
         else
            digits <= {digits[3] - 4'd1, NINE, FIVE, NINE};
      end
   end

endmodule

// File: rtl/sequenciador_cozimento.sv
// Cooking sequencer: button edge detect, cook/pause/done FSM, beep timing and magnetron gating.
module sequenciador_cozimento
   import sequenciador_cozimento_pkg::*;
#(
   parameter int BEEP_TICKS = 3
) (
   input  logic                      clock,
   input  logic                      resetn,
   sequenciador_cozimento_if.slave   bus
);

   localparam logic [3:0] BEEP_LAST = 4'(BEEP_TICKS - 1);

   estado_t    state_q;
   logic       start_q, stop_q, clear_q;
   logic       done_q, beep_q;
   logic [3:0] beep_cnt;
   tempo_t     digits;
   logic       zero, last;
   logic       start_e, stop_e, clear_e, any_e;
   logic       clr, load, dec;

   assign start_e = start_q & ~bus.startn;
   assign stop_e  = stop_q  & ~bus.stopn;
   assign clear_e = clear_q & ~bus.clearn;
   assign any_e   = start_e | stop_e | clear_e;

   assign clr  = clear_e | ((state_q == PAUSE) & stop_e);
   assign load = (state_q == IDLE) & bus.key_valid & is_bcd(bus.key_digit);
   assign dec  = (state_q == COOK) & bus.tick_1hz;

   contador_bcd_regressivo u_contador (
      .clock    (clock),
      .resetn   (resetn),
      .clr      (clr),
      .load     (load),
      .digit_in (bus.key_digit),
      .dec      (dec),
      .digits   (digits),
      .zero     (zero),
      .last     (last)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         start_q  <= 1'b1;
         stop_q   <= 1'b1;
         clear_q  <= 1'b1;
         done_q   <= 1'b0;
         beep_q   <= 1'b0;
         beep_cnt <= '0;
      end else begin
         start_q <= bus.startn;
         stop_q  <= bus.stopn;
         clear_q <= bus.clearn;
         case (state_q)
            IDLE: begin
               if (!clear_e && start_e && bus.door_closed && !zero)
                  state_q <= COOK;
            end
            COOK: begin
               if (clear_e) begin
                  state_q <= IDLE;
               end else if (bus.tick_1hz && last) begin
                  // Reaching 00:00 outranks a concurrent stop or door open.
                  state_q  <= DONE;
                  done_q   <= 1'b1;
                  beep_q   <= 1'b1;
                  beep_cnt <= '0;
               end else if (stop_e || !bus.door_closed) begin
                  state_q <= PAUSE;
               end
            end
            PAUSE: begin
               if (clear_e || stop_e)
                  state_q <= IDLE;
               else if (start_e && bus.door_closed)
                  state_q <= COOK;
            end
            DONE: begin
               if (any_e || (bus.tick_1hz && beep_cnt == BEEP_LAST)) begin
                  state_q <= IDLE;
                  done_q  <= 1'b0;
                  beep_q  <= 1'b0;
               end else if (bus.tick_1hz) begin
                  beep_cnt <= beep_cnt + 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.min_tens   = digits[3];
   assign bus.min_ones   = digits[2];
   assign bus.sec_tens   = digits[1];
   assign bus.sec_ones   = digits[0];
   assign bus.state      = state_q;
   assign bus.timer_done = done_q;
   assign bus.beep       = beep_q;
   // Door opening cuts the magnetron immediately, ahead of the PAUSE transition.
   assign bus.mag_on     = (state_q == COOK) & bus.door_closed;

endmodule

// File: tb/tb_sequenciador_cozimento.sv
// Directed self-checking bench for the cooking sequencer.
module tb_sequenciador_cozimento;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   int   errors = 0;
   int   checks = 0;

   sequenciador_cozimento_if bus ();

   sequenciador_cozimento #(.BEEP_TICKS(3)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic key(input logic [3:0] d);
      bus.key_valid = 1'b1;
      bus.key_digit = d;
      step();
      bus.key_valid = 1'b0;
      bus.key_digit = 4'd0;
   endtask

   task automatic tick();
      bus.tick_1hz = 1'b1;
      step();
      bus.tick_1hz = 1'b0;
   endtask

   task automatic press_start();
      bus.startn = 1'b0; step(); bus.startn = 1'b1; step();
   endtask

   task automatic press_stop();
      bus.stopn = 1'b0; step(); bus.stopn = 1'b1; step();
   endtask

   task automatic press_clear();
      bus.clearn = 1'b0; step(); bus.clearn = 1'b1; step();
   endtask

   function automatic logic [31:0] tempo();
      return {16'h0, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
   endfunction

   initial begin
      bus.tick_1hz = 1'b0; bus.startn = 1'b1; bus.stopn = 1'b1; bus.clearn = 1'b1;
      bus.door_closed = 1'b1; bus.key_valid = 1'b0; bus.key_digit = 4'd0;
      step(); step();
      chk("rst_state", bus.state, 0);
      chk("rst_time", tempo(), 32'h0000);
      chk("rst_mag", bus.mag_on, 0);
      chk("rst_done", bus.timer_done, 0);
      chk("rst_beep", bus.beep, 0);
      resetn = 1'b1;
      step();

      // 1,3,0 -> 01:30, cook 3 s -> 01:27
      key(1); key(3); key(0);
      chk("entry_130", tempo(), 32'h0130);
      press_start();
      chk("cook_state", bus.state, 1);
      chk("cook_mag", bus.mag_on, 1);
      tick(); tick(); tick();
      chk("cook_127", tempo(), 32'h0127);
      chk("cook_127_mag", bus.mag_on, 1);
      chk("cook_127_state", bus.state, 1);
      press_clear();
      chk("clr_cook_state", bus.state, 0);
      chk("clr_cook_time", tempo(), 32'h0000);

      // 00:02 to DONE, beep for 3 ticks
      key(2); key(12);
      chk("bad_key", tempo(), 32'h0002);
      press_start();
      tick(); tick();
      chk("done_state", bus.state, 3);
      chk("done_time", tempo(), 32'h0000);
      chk("done_flag", bus.timer_done, 1);
      chk("done_beep", bus.beep, 1);
      chk("done_mag", bus.mag_on, 0);
      tick(); tick();
      chk("done_hold", bus.state, 3);
      chk("done_hold_beep", bus.beep, 1);
      tick();
      chk("beep_end_state", bus.state, 0);
      chk("beep_end_beep", bus.beep, 0);
      chk("beep_end_done", bus.timer_done, 0);

      // door open at 00:45
      key(4); key(5);
      press_start();
      bus.door_closed = 1'b0;
      #1;
      chk("door_mag_now", bus.mag_on, 0);
      chk("door_still_cook", bus.state, 1);
      step();
      chk("door_pause", bus.state, 2);
      bus.door_closed = 1'b1;
      tick();
      chk("pause_frozen", tempo(), 32'h0045);
      chk("pause_mag", bus.mag_on, 0);
      press_start();
      chk("resume_state", bus.state, 1);
      chk("resume_time", tempo(), 32'h0045);
      chk("resume_mag", bus.mag_on, 1);
      press_stop();
      chk("stop_pause", bus.state, 2);
      press_stop();
      chk("stop2_idle", bus.state, 0);
      chk("stop2_time", tempo(), 32'h0000);

      // borrow cases
      key(1); key(0); key(0); press_start(); tick();
      chk("borrow_100", tempo(), 32'h0059);
      press_clear();
      key(9); key(0); press_start(); tick();
      chk("borrow_090", tempo(), 32'h0089);
      press_clear();
      key(1); key(0); key(0); key(0); press_start(); tick();
      chk("borrow_1000", tempo(), 32'h0959);
      press_clear();

      // rejected starts
      press_start();
      chk("start_zero", bus.state, 0);
      chk("start_zero_mag", bus.mag_on, 0);
      key(5);
      bus.door_closed = 1'b0;
      press_start();
      chk("start_open", bus.state, 0);
      chk("start_open_mag", bus.mag_on, 0);
      bus.door_closed = 1'b1;

      // held start triggers once
      bus.startn = 1'b0;
      step();
      chk("held_cook", bus.state, 1);
      bus.stopn = 1'b0; step(); bus.stopn = 1'b1; step();
      chk("held_pause", bus.state, 2);
      for (int i = 0; i < 8; i++) step();
      chk("held_no_retrig", bus.state, 2);
      bus.startn = 1'b1;
      step();
      chk("held_release", bus.state, 2);
      chk("held_time", tempo(), 32'h0005);
      press_clear();

      // all three buttons together in COOK
      key(3); press_start();
      bus.startn = 1'b0; bus.stopn = 1'b0; bus.clearn = 1'b0;
      step();
      chk("all_btn_state", bus.state, 0);
      chk("all_btn_time", tempo(), 32'h0000);
      bus.startn = 1'b1; bus.stopn = 1'b1; bus.clearn = 1'b1;
      step();

      // tick + stop together
      key(1); key(0); press_start();
      bus.stopn = 1'b0; bus.tick_1hz = 1'b1; step();
      bus.stopn = 1'b1; bus.tick_1hz = 1'b0; step();
      chk("tick_stop_state", bus.state, 2);
      chk("tick_stop_time", tempo(), 32'h0009);
      press_clear();
      key(1); press_start();
      bus.stopn = 1'b0; bus.tick_1hz = 1'b1; step();
      bus.stopn = 1'b1; bus.tick_1hz = 1'b0; step();
      chk("done_wins", bus.state, 3);
      press_clear();
      chk("done_btn_idle", bus.state, 0);
      chk("done_btn_beep", bus.beep, 0);

      // reset mid-cook
      key(7); press_start();
      chk("pre_rst_mag", bus.mag_on, 1);
      resetn = 1'b0;
      #1;
      chk("async_rst_mag", bus.mag_on, 0);
      chk("async_rst_state", bus.state, 0);
      chk("async_rst_time", tempo(), 32'h0000);
      chk("async_rst_beep", bus.beep, 0);
      step();
      resetn = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
